// File: rtl/store_buffer_if.sv
// Request/port bundle between the MEM stage, the store buffer and the data memory.
// The pipeline side drives req_*; the buffer drives stall, the memory port and the fill status.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) ();
    logic                     req_valid;
    logic                     req_write;
    logic [AW-1:0]            req_addr;
    logic [31:0]              req_wdata;
    logic [2:0]               req_funct3;

    logic                     stall;
    logic                     mem_write;
    logic [AW-1:0]            mem_addr;
    logic [31:0]              mem_wdata;
    logic [2:0]               mem_funct3;
    logic                     sb_empty;
    logic [$clog2(DEPTH):0]   sb_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  stall, mem_write, mem_addr, mem_wdata, mem_funct3, sb_empty, sb_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output stall, mem_write, mem_addr, mem_wdata, mem_funct3, sb_empty, sb_count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of a single-port data memory: loads take the port first,
// buffered stores drain in free cycles, and a load touching a buffered word stalls until it drains.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic         clk,
    input  logic         reset,
    store_buffer_if.slave bus
);
    localparam int             PW         = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [2:0]    funct3;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;

    logic full;
    logic load_hit;
    logic load_go;
    logic drain;
    logic enqueue;

    assign full = (count == FULL_COUNT);

    // Word-granular match against every live entry; deliberately ignores byte lanes.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        load_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[AW-1:2] == bus.req_addr[AW-1:2])) begin
                load_hit = 1'b1;
            end
        end
        load_hit = load_hit & bus.req_valid & ~bus.req_write;
    end

    assign load_go   = bus.req_valid & ~bus.req_write & ~load_hit;
    assign drain     = ~load_go & (count != '0);
    assign enqueue   = bus.req_valid & bus.req_write & (~full | drain);
    assign bus.stall = load_hit | (bus.req_valid & bus.req_write & full & ~drain);

    // Idle and hazard-free loads both present the request address; only a drain overrides it.
    always_comb begin
        bus.mem_write  = 1'b0;
        bus.mem_addr   = bus.req_addr;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = bus.req_funct3;
        if (drain) begin
            bus.mem_write  = 1'b1;
            bus.mem_addr   = entries[head].addr;
            bus.mem_wdata  = entries[head].wdata;
            bus.mem_funct3 = entries[head].funct3;
        end
    end

    // When full, a drain and an enqueue hit the same slot; the enqueue's valid set must win.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (enqueue) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({enqueue, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry payload is not reset; the valid bits alone decide whether a slot is live.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            entries[tail] <= '{addr: bus.req_addr, wdata: bus.req_wdata, funct3: bus.req_funct3};
        end
    end

    assign bus.sb_empty = (count == '0);
    assign bus.sb_count = count;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of the buffer plus a byte-addressed
// architectural memory predict every cycle's port, stall and fill status, and the data loads see.
module tb_store_buffer;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        stall;
        logic        mem_write;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [2:0]  mem_funct3;
        logic        sb_empty;
        logic [2:0]  sb_count;
        logic [31:0] rdata;
    } snap_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } st_t;

    st_t         model_q [$];
    logic [7:0]  arch_mem [logic [31:0]];
    logic [7:0]  phys_mem [logic [31:0]];
    logic [31:0] drain_log [$];
    logic [2:0]  ld_codes [5];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [7:0] rd_byte(input bit phys, input logic [31:0] a);
        if (phys) return phys_mem.exists(a) ? phys_mem[a] : 8'h00;
        return arch_mem.exists(a) ? arch_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_load(input bit phys, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] w;
        w = {rd_byte(phys, a + 32'd3), rd_byte(phys, a + 32'd2), rd_byte(phys, a + 32'd1), rd_byte(phys, a)};
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic mem_store(input bit phys, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int n;
        n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            if (phys) phys_mem[a + 32'(i)] = d[8*i +: 8];
            else      arch_mem[a + 32'(i)] = d[8*i +: 8];
        end
    endtask

    function automatic string fmt(input snap_t s);
        return $sformatf("stall=%b mw=%b addr=%h wd=%h f3=%b empty=%b cnt=%0d rd=%h",
                         s.stall, s.mem_write, s.mem_addr, s.mem_wdata, s.mem_funct3,
                         s.sb_empty, s.sb_count, s.rdata);
    endfunction

    // Drives one request for one cycle, predicts the outputs from the model, captures the DUT
    // mid-cycle, then commits the edge to the model and to the memory the DUT writes.
    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic rst, output snap_t obs, output snap_t exp);
        logic hit, load_go, drain, enq, full;
        st_t  ent;
        reset          = rst;
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_funct3 = f;
        @(negedge clk);
        hit = 1'b0;
        foreach (model_q[i]) if (model_q[i].addr[31:2] == a[31:2]) hit = 1'b1;
        hit     = hit & v & ~w;
        load_go = v & ~w & ~hit;
        drain   = !load_go && (model_q.size() > 0);
        full    = (model_q.size() == DEPTH);
        enq     = v & w & (~full | drain);
        exp.stall      = hit | (v & w & full & ~drain);
        exp.mem_write  = drain;
        exp.mem_addr   = drain ? model_q[0].addr : a;
        exp.mem_wdata  = drain ? model_q[0].data : 32'h0;
        exp.mem_funct3 = drain ? model_q[0].f3   : f;
        exp.sb_empty   = (model_q.size() == 0);
        exp.sb_count   = 3'(model_q.size());
        exp.rdata      = load_go ? mem_load(1'b0, a, f) : 32'h0;
        obs.stall      = bus.stall;
        obs.mem_write  = bus.mem_write;
        obs.mem_addr   = bus.mem_addr;
        obs.mem_wdata  = load_go ? 32'h0 : bus.mem_wdata;  // write data is meaningless under a load
        obs.mem_funct3 = bus.mem_funct3;
        obs.sb_empty   = bus.sb_empty;
        obs.sb_count   = bus.sb_count;
        obs.rdata      = load_go ? mem_load(1'b1, bus.mem_addr, bus.mem_funct3) : 32'h0;
        @(posedge clk);
        if (obs.mem_write === 1'b1) begin
            mem_store(1'b1, obs.mem_addr, bus.mem_wdata, obs.mem_funct3);
            drain_log.push_back(obs.mem_addr);
        end
        if (rst) begin
            model_q.delete();
            arch_mem = phys_mem;
        end else begin
            if (drain) void'(model_q.pop_front());
            if (enq) begin
                ent.addr = a; ent.data = d; ent.f3 = f;
                model_q.push_back(ent);
                mem_store(1'b0, a, d, f);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        snap_t o, e;
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b1, o, e);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b1, o, e);
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 1'b0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_model: got %s want %s", fmt(o), fmt(e)); end
        total++;
        if (o.sb_empty !== 1'b1 || o.sb_count !== 3'd0 || o.mem_write !== 1'b0 || o.stall !== 1'b0) begin
            bad++; $display("FAIL reset_state: got %s want empty=1 cnt=0 mw=0 stall=0", fmt(o));
        end
    endtask

    task automatic test_single_store();
        snap_t o, e;
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL sw_accept: got %s want %s", fmt(o), fmt(e)); end
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
        total++;
        if (o.mem_write !== 1'b1 || o.mem_addr !== 32'h10 || o.mem_funct3 !== 3'b010 || o.mem_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL sw_drain: got %s want mw=1 addr=00000010 f3=010 wd=deadbeef", fmt(o));
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
        total++;
        if (o.sb_empty !== 1'b1 || o.mem_write !== 1'b0) begin
            bad++; $display("FAIL sw_empty_after: got %s want empty=1 mw=0", fmt(o));
        end
    endtask

    task automatic test_back_to_back();
        snap_t o, e;
        logic [31:0] want [4];
        bit          ok;
        drain_log.delete();
        for (int k = 0; k < 4; k++) begin
            want[k] = 32'h21 + 32'(k);
            step(1'b1, 1'b1, want[k], 32'hA0 + 32'(k), 3'b000, 1'b0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b_sb%0d: got %s want %s", k, fmt(o), fmt(e)); end
        end
        step(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1'b0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL b2b_load: got %s want %s", fmt(o), fmt(e)); end
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
        ok = (drain_log.size() == 4);
        for (int k = 0; k < 4 && ok; k++) if (drain_log[k] !== want[k]) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_order: got %p want 21,22,23,24", drain_log); end
    endtask

    task automatic test_load_hazard();
        snap_t o, e;
        int    n;
        step(1'b1, 1'b1, 32'h40, 32'h1234_5678, 3'b010, 1'b0, o, e);
        n = 0;
        do begin
            step(1'b1, 1'b0, 32'h43, 32'h0, 3'b100, 1'b0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL hazard_cycle%0d: got %s want %s", n, fmt(o), fmt(e)); end
            if (n == 0) begin
                total++;
                if (o.stall !== 1'b1 || o.mem_write !== 1'b1) begin
                    bad++; $display("FAIL hazard_stall: got %s want stall=1 mw=1", fmt(o));
                end
            end
            n++;
        end while (e.stall && n < 8);
        total++;
        if (e.stall) begin bad++; $display("FAIL hazard_timeout: stall still expected after %0d cycles", n); end
        total++;
        if (o.rdata !== 32'h12 || o.stall !== 1'b0) begin
            bad++; $display("FAIL hazard_lbu_data: got %s want stall=0 rd=00000012", fmt(o));
        end
    endtask

    task automatic test_loads_block_drain();
        snap_t o, e;
        step(1'b1, 1'b1, 32'h80, 32'h0000_55AA, 3'b001, 1'b0, o, e);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'h200, 32'h0, 3'b010, 1'b0, o, e);
            total++;
            if (o !== e || o.mem_write !== 1'b0 || o.sb_count !== 3'd1) begin
                bad++; $display("FAIL loads_hold%0d: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
        total++;
        if (o.mem_write !== 1'b1 || o.mem_addr !== 32'h80 || o.mem_funct3 !== 3'b001) begin
            bad++; $display("FAIL loads_then_drain: got %s want mw=1 addr=00000080 f3=001", fmt(o));
        end
    endtask

    task automatic test_wrap();
        snap_t o, e;
        bit    ok;
        drain_log.delete();
        for (int k = 0; k < 2*DEPTH + 1; k++) begin
            step(1'b1, 1'b1, 32'h400 + 32'(4*k), 32'h0101_0101 * 32'(k + 1), 3'b010, 1'b0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL wrap_st%0d: got %s want %s", k, fmt(o), fmt(e)); end
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
        ok = (drain_log.size() == 2*DEPTH + 1);
        for (int k = 0; k < 2*DEPTH + 1 && ok; k++) if (drain_log[k] !== 32'h400 + 32'(4*k)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_order: got %p want 400,404,...", drain_log); end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        step(1'b1, 1'b1, 32'h300, 32'hAAAA_5555, 3'b010, 1'b0, o, e);
        step(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 1'b0, o, e);
        total++;
        if (o.sb_count !== 3'd1 || o.mem_write !== 1'b0) begin
            bad++; $display("FAIL rstmid_pending: got %s want cnt=1 mw=0", fmt(o));
        end
        step(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 1'b1, o, e);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, o, e);
            total++;
            if (o.mem_write !== 1'b0 || o.sb_count !== 3'd0 || o.sb_empty !== 1'b1) begin
                bad++; $display("FAIL rstmid_idle%0d: got %s want mw=0 cnt=0 empty=1", k, fmt(o));
            end
        end
        step(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 1'b0, o, e);
        total++;
        if (o !== e || o.rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_discarded: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_random();
        snap_t       o, e;
        logic        v, w, rst, held;
        logic [31:0] a, d;
        logic [2:0]  f;
        ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
        ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
        held = 1'b0; v = 1'b0; w = 1'b0; a = '0; d = '0; f = '0; rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!held) begin
                v   = ($urandom_range(0, 7) != 0);
                w   = 1'($urandom_range(0, 1));
                f   = w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
                a   = 32'($urandom_range(0, 15)) << 2;
                if (f[1:0] == 2'b00)      a = a + 32'($urandom_range(0, 3));
                else if (f[1:0] == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
                d   = $urandom;
                rst = ($urandom_range(0, 63) == 0);
            end
            step(v, w, a, d, f, rst, o, e);
            if (!rst) begin
                total++;
                if (o !== e) begin bad++; $display("FAIL random_c%0d: got %s want %s", c, fmt(o), fmt(e)); end
            end
            held = e.stall && !rst;
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_load_hazard();
        test_loads_block_drain();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
